// File: rtl/cursor_pkg.sv
// Shared definitions for the hardware cursor overlay.
//   mode_e        : cursor drawing mode as carried on the 2-bit mode port
//   click_state_e : click-flash state machine states
//   CURSOR_COLOR  : normal cursor colour (RRRGGGBB)
//   CLICK_COLOR   : colour shown while a click flash is running
package cursor_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_OUTLINE = 2'b10,
    MODE_CROSS   = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } click_state_e;

  localparam logic [7:0] CURSOR_COLOR = 8'hFF;
  localparam logic [7:0] CLICK_COLOR  = 8'hE0;

endpackage

// File: rtl/cursor_shape_hit.sv
// Combinational hit test for one pixel against the cursor shape.
//   x, y                     : pixel under test
//   cx, cy                   : cursor centre (used by the crosshair)
//   left, right, top, bottom : inclusive, already-saturated cursor box
//   mode                     : cursor mode (mode_e encoding)
//   hit                      : pixel belongs to the cursor shape
module cursor_shape_hit
  import cursor_pkg::*;
#(
  parameter int COORD_W = 11
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] left,
  input  logic [COORD_W-1:0] right,
  input  logic [COORD_W-1:0] top,
  input  logic [COORD_W-1:0] bottom,
  input  logic [1:0]         mode,
  output logic               hit
);

  logic in_x, in_y, on_edge;

  assign in_x    = (x >= left) && (x <= right);
  assign in_y    = (y >= top)  && (y <= bottom);
  // Edges are the saturated bounds, so a cursor clipped at the screen
  // border draws its outline along the border.
  assign on_edge = (x == left) || (x == right) || (y == top) || (y == bottom);

  always_comb begin
    hit = 1'b0;
    case (mode_e'(mode))
      MODE_SOLID:   hit = in_x && in_y;
      MODE_OUTLINE: hit = in_x && in_y && on_edge;
      MODE_CROSS:   hit = ((x == cx) && in_y) || ((y == cy) && in_x);
      default:      hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/cursor_overlay.sv
// Hardware cursor overlay for a pixel stream.
//   clk, rst           : pixel clock, synchronous active-high reset
//   x, y, valid        : current pixel position and active-video flag
//   frame_start        : one-cycle pulse at the start of each frame
//   cursor_x, cursor_y : requested cursor centre (sampled on frame_start)
//   mode               : 00 off, 01 solid, 10 outline, 11 crosshair
//                        (sampled on frame_start)
//   blink_en           : blink the cursor every BLINK_FRAMES frames
//   click              : one-cycle pulse, starts/restarts the click flash
//   rgb, active        : registered cursor colour / presence, one cycle
//                        after the pixel
module cursor_overlay
  import cursor_pkg::*;
#(
  parameter int COORD_W      = 11,
  parameter int SIZE         = 7,
  parameter int BLINK_FRAMES = 30,
  parameter int FLASH_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               valid,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] cursor_x,
  input  logic [COORD_W-1:0] cursor_y,
  input  logic [1:0]         mode,
  input  logic               blink_en,
  input  logic               click,
  output logic [7:0]         rgb,
  output logic               active
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  localparam logic [COORD_W-1:0] HALF       = COORD_W'(SIZE / 2);
  localparam logic [COORD_W-1:0] CMAX       = '1;
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0]      FLASH_LOAD = FW'(FLASH_FRAMES);

  // Frame-stable copies of the cursor request; drawing only ever uses these.
  logic [COORD_W-1:0] cx_q, cy_q;
  mode_e              mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q   <= '0;
      cy_q   <= '0;
      mode_q <= MODE_OFF;
    end else if (frame_start) begin
      cx_q   <= cursor_x;
      cy_q   <= cursor_y;
      mode_q <= mode_e'(mode);
    end
  end

  // Cursor box, clamped to the coordinate range instead of wrapping.
  logic [COORD_W:0]   right_sum, bottom_sum;
  logic [COORD_W-1:0] left, right, top, bottom;

  assign right_sum  = {1'b0, cx_q} + {1'b0, HALF};
  assign bottom_sum = {1'b0, cy_q} + {1'b0, HALF};
  assign left   = (cx_q >= HALF) ? (cx_q - HALF) : '0;
  assign top    = (cy_q >= HALF) ? (cy_q - HALF) : '0;
  assign right  = right_sum[COORD_W]  ? CMAX : right_sum[COORD_W-1:0];
  assign bottom = bottom_sum[COORD_W] ? CMAX : bottom_sum[COORD_W-1:0];

  logic hit;

  cursor_shape_hit #(.COORD_W(COORD_W)) u_hit (
    .x      (x),
    .y      (y),
    .cx     (cx_q),
    .cy     (cy_q),
    .left   (left),
    .right  (right),
    .top    (top),
    .bottom (bottom),
    .mode   (mode_q),
    .hit    (hit)
  );

  // Blink: count frames while enabled, toggle visibility on each wrap.
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          visible_q, visible_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      visible_d   = 1'b1;
    end else if (frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        visible_d   = ~visible_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
    end
  end

  // Click flash state machine.
  click_state_e  state_q, state_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic [7:0]    color;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flash_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flash_cnt_q <= flash_cnt_d;
    end
  end

  // A click always reloads, so it takes priority over a coincident
  // frame_start decrement.
  always_comb begin
    state_d     = state_q;
    flash_cnt_d = flash_cnt_q;
    if (click) begin
      state_d     = FLASH;
      flash_cnt_d = FLASH_LOAD;
    end else if (state_q == FLASH) begin
      if (flash_cnt_q == '0) begin
        state_d = IDLE;
      end else if (frame_start) begin
        flash_cnt_d = flash_cnt_q - FW'(1);
      end
    end
  end

  always_comb begin
    color = CURSOR_COLOR;
    if (state_q == FLASH) color = CLICK_COLOR;
  end

  // Output stage.
  logic       pix_on;
  logic       active_q;
  logic [7:0] rgb_q;

  assign pix_on = valid && hit && visible_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      rgb_q    <= 8'h00;
    end else begin
      active_q <= pix_on;
      rgb_q    <= pix_on ? color : 8'h00;
    end
  end

  assign active = active_q;
  assign rgb    = rgb_q;

endmodule
